accumulating_calculator: RTL
============================

Name: accumulating_calculator

Overview:
Parametrised sequential successor to the combinational switch adder. Keeps a 2*WIDTH-bit accumulator and applies one operation per press of the enter key: add, subtract, multiply or load. The operand comes from the switches. Multiply is a multi-cycle shift-add operation. The accumulator is shown as hex on NUM_HEX seven-segment displays.

Parameters:
WIDTH, 4, operand width in bits; the accumulator is 2*WIDTH bits wide.
NUM_HEX, (2*WIDTH+3)/4 (derived localparam, not overridable), number of seven-segment digits.

Ports:
CLOCK_50  input  1  system clock.
RESET_N  input  1  asynchronous reset, active-low.
SW  input  WIDTH  operand.
OP  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 LOAD. Sampled on the go pulse.
ENTER_N  input  1  enter push-button, active-low, asynchronous to the clock.
BUSY  output  1  high while an operation executes.
OVF  output  1  carry/borrow of the last completed operation.
HEX  output  NUM_HEX*7  active-low segments. Digit k is HEX[7k+6:7k] and shows accumulator nibble k.

Behaviour:
- Reset is asynchronous and active-low (RESET_N low); all flops clear.
  - acc = 0, OVF = 0, BUSY = 0, FSM = IDLE, synchroniser flops = 1 (key released).
  - Every HEX digit shows "0" (7'b1000000).
  - Reset mid-MUL aborts the multiply; no partial result is kept.
- Input path: ENTER_N passes through a 2-flop synchroniser. A falling edge (press) of the synchronised signal creates a single-cycle go pulse.
  - Go pulses are ignored unless FSM = IDLE; there is no queueing.
  - A held key produces exactly one go pulse.
- On a go pulse, SW and OP are registered into operand/op registers. Later switch changes do not affect the running operation.
- FSM has three states: IDLE, EXEC, MUL.
  - IDLE -> EXEC on go with OP != MUL.
  - IDLE -> MUL on go with OP = MUL; the bit counter is loaded with WIDTH.
  - EXEC -> IDLE after 1 cycle; acc and OVF are written on this transition.
  - MUL -> IDLE once the counter reaches 0; acc and OVF are written on the last iteration.
- BUSY = (FSM != IDLE), registered.
- Latency is counted from the go-pulse cycle:
  - ADD/SUB/LOAD: new acc is visible 2 cycles later.
  - MUL: new acc is visible WIDTH+2 cycles later.
  - BUSY is high for 1 cycle (ADD/SUB/LOAD) or WIDTH+1 cycles (MUL).
- Arithmetic: the operand is zero-extended to 2*WIDTH bits and results wrap modulo 2^(2*WIDTH).
  - ADD: acc + op. OVF = carry out of bit 2*WIDTH-1.
  - SUB: acc - op. OVF = borrow (op > acc).
  - MUL: acc[WIDTH-1:0] * op via shift-add, one multiplier bit per cycle, LSB first. Upper acc bits are discarded before the multiply. OVF = 0, since the product always fits.
  - LOAD: acc = op. OVF = 0.
- OVF holds until the next operation completes.
- HEX is combinational from acc through the existing nibble decoder. All NUM_HEX digits are always driven; the top nibble is zero-padded when 2*WIDTH is not a multiple of 4.
- Boundaries:
  - acc = 2^(2W)-1 with ADD 1 -> acc 0, OVF = 1.
  - acc = 0 with SUB 0 -> 0, OVF = 0.
  - MUL with op = 0 -> 0.
  - Press in the same cycle the FSM returns to IDLE: ignored (FSM is not yet IDLE when sampled).

Decomposition:
- Package calc_pkg: typedef enum op_t {OP_ADD, OP_SUB, OP_MUL, OP_LOAD}; typedef enum state_t {IDLE, EXEC, MUL}; constant SEG_ZERO = 7'b1000000.
- Sub-module seq_multiplier (WIDTH): start, a, b in; done, product out; shift-add, WIDTH cycles.
- The existing decoder is instantiated NUM_HEX times in a generate loop.

Test Plan:
1. WIDTH=4, reset, then LOAD 9 -> acc=0x09, HEX1/HEX0 show "0"/"9", OVF=0, BUSY high 1 cycle.
2. From acc=0x09, ADD 7 -> acc=0x10. Then from acc=0xFE, ADD 5 -> acc=0x03, OVF=1.
3. LOAD 3, then SUB 5 -> acc=0xFE, OVF=1. Then SUB 0 -> acc=0xFE, OVF=0.
4. LOAD 12, then MUL 13 -> BUSY high exactly 5 cycles. acc=0x9C at go+6, OVF=0. Toggling SW during the MUL does not change the result.
5. ENTER_N held low for 100 cycles -> exactly one operation. A second press while BUSY=1 is ignored (acc reflects one op only).
6. RESET_N low mid-MUL (cycle 2) -> acc=0, BUSY=0, HEX all 7'b1000000 immediately. After release, the next LOAD 5 works normally.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the accumulating calculator
package calc_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_LOAD = 2'b11} op_t;
   typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, MUL = 2'b10} state_t;
   localparam logic [6:0] SEG_ZERO = 7'b1000000;
endpackage

// File: rtl/hex_decoder.sv
// hex_decoder: nibble to active-low seven-segment pattern
module hex_decoder
   import calc_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);
   // one segment pattern per hex value, gfedcba order, active-low
   always_comb begin
      seg_o = SEG_ZERO;
      case (nibble_i)
         4'h0: seg_o = SEG_ZERO;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         default: seg_o = 7'b0001110;
      endcase
   end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per cycle, LSB first
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               run_q, run_d;
   assign done_o    = run_q && (cnt_q == '0);
   assign product_o = prod_q;
   // load operands on start, then add the shifted multiplicand for each set multiplier bit
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         prod_d   = '0;
         cnt_d    = CW'(WIDTH);
         run_d    = 1'b1;
      end else if (run_q) begin
         if (cnt_q != '0) begin
            prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
         end else begin
            run_d = 1'b0;
         end
      end
   end
   // datapath registers, cleared so a reset mid-multiply leaves nothing behind
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end
endmodule

// File: rtl/accumulating_calculator.sv
// accumulating_calculator: key-driven accumulator with add/sub/mul/load and hex display
module accumulating_calculator
   import calc_pkg::*;
#(
   parameter  int WIDTH   = 4,
   localparam int NUM_HEX = (2 * WIDTH + 3) / 4
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   input  logic [WIDTH-1:0]     SW,
   input  logic [1:0]           OP,
   input  logic                 ENTER_N,
   output logic                 BUSY,
   output logic                 OVF,
   output logic [NUM_HEX*7-1:0] HEX
);
   localparam int AW = 2 * WIDTH;
   logic [2:0]          sync_q;
   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   logic [WIDTH-1:0]    operand_q, operand_d;
   logic [AW-1:0]       acc_q, acc_d, opx, product;
   logic                ovf_q, ovf_d, busy_q;
   logic [AW:0]         sum, diff;
   logic                go, accept, mul_start, mul_done;
   logic [4*NUM_HEX-1:0] padded;
   assign go        = sync_q[2] & ~sync_q[1];
   assign accept    = go && (state_q == IDLE);
   assign mul_start = accept && (op_t'(OP) == OP_MUL);
   assign opx       = {{WIDTH{1'b0}}, operand_q};
   assign sum       = {1'b0, acc_q} + {1'b0, opx};
   assign diff      = {1'b0, acc_q} - {1'b0, opx};
   assign BUSY      = busy_q;
   assign OVF       = ovf_q;
   assign padded    = (4 * NUM_HEX)'(acc_q);
   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk_i     (CLOCK_50),
      .rst_n_i   (RESET_N),
      .start_i   (mul_start),
      .a_i       (acc_q[WIDTH-1:0]),
      .b_i       (SW),
      .done_o    (mul_done),
      .product_o (product)
   );
   // next state: capture the operation on an accepted press, commit the result on the way back to IDLE
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      operand_d = operand_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: if (accept) begin
            op_d      = op_t'(OP);
            operand_d = SW;
            state_d   = (op_t'(OP) == OP_MUL) ? MUL : EXEC;
         end
         EXEC: begin
            state_d = IDLE;
            acc_d   = (op_q == OP_ADD) ? sum[AW-1:0] : (op_q == OP_SUB) ? diff[AW-1:0] : opx;
            ovf_d   = (op_q == OP_ADD) ? sum[AW] : (op_q == OP_SUB) ? diff[AW] : 1'b0;
         end
         MUL: if (mul_done) begin
            state_d = IDLE;
            acc_d   = product;
            ovf_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   // key synchroniser (idles high = released) and all control/datapath state
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q    <= 3'b111;
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         operand_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[1:0], ENTER_N};
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         busy_q    <= (state_d != IDLE);
      end
   end
   for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
      hex_decoder u_dec (
         .nibble_i (padded[4*g +: 4]),
         .seg_o    (HEX[7*g +: 7])
      );
   end
endmodule
